mc_controller: RTL and testbench
================================

# mc_controller

Multicycle main controller for the MIPS-subset datapath. An FSM steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It supplies the 2-bit `aluop` consumed by the ALU decoder. It waits on a memory ready handshake and flags unsupported opcodes.

## Interface
Parameters:
- `MEM_WAIT`, default 1: 1 = stall FETCH/MEMRD/MEMWR until `mem_ready`; 0 = treat `mem_ready` as always 1.

Ports:
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous active-low reset.
- `op` in 6: instruction opcode field (IR[31:26]), valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `pcen` out 1: PC register write enable.
- `irwrite` out 1: instruction register load.
- `memwrite` out 1: data memory write request.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `regwrite` out 1: register file write.
- `regdst` out 1: destination select (0 = rt, 1 = rd).
- `memtoreg` out 1: writeback select (0 = ALUOut, 1 = MDR).
- `alusrca` out 1: ALU A select (0 = PC, 1 = regA).
- `alusrcb` out 2: ALU B select (00 regB, 01 const 4, 10 signimm, 11 signimm<<2).
- `pcsrc` out 2: next-PC select (00 ALU result, 01 ALUOut, 10 jump target).
- `aluop` out 2: 00 add, 01 sub, 10 decode by funct.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `illegal_op` out 1: sticky flag for an unsupported opcode, cleared only by reset.
- `state` out 4: current state, for debug.

## Operation
- Supported opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- The state register is the only storage besides `illegal_op`. Outputs are decoded from state.
- Exception: `irwrite`, `pcen`, `memwrite` and the FETCH/MEMRD/MEMWR exits also gate on `mem_ready`.
- Any output not listed for a state is 0.
- States and outputs:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. When `mem_ready`: irwrite=1, pcen=1, go to DECODE. Otherwise stay.
  - DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Dispatch on `op`:
    - LW/SW → MEMADR
    - RTYPE → RTYPEEX
    - BEQ → BEQEX
    - ADDI → ADDIEX
    - J → JEX
    - other → set `illegal_op`, pulse `instr_done`, go to FETCH.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. LW → MEMRD, SW → MEMWR.
  - MEMRD: iord=1. When `mem_ready` → MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1 → FETCH.
  - MEMWR: iord=1, memwrite=1. `memwrite` is held until `mem_ready`, then → FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10 → RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1 → FETCH.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=`zero` → FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00 → ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1 → FETCH.
  - JEX: pcsrc=10, pcen=1 → FETCH.
- `instr_done` is 1 in the cycle that transitions to FETCH from MEMWB, MEMWR (with ready), RTYPEWB, BEQEX, ADDIWB, JEX, or DECODE on an illegal opcode.

## Timing
- Reset (async assert, any state, including mid memory wait): state=FETCH, all outputs 0, `illegal_op`=0.
- Release is synchronous to `clk`. The first fetch strobe can occur in the first cycle after deassertion if `mem_ready`=1.
- Cycle counts with zero wait states:
  - LW 5
  - SW 4
  - RTYPE 4
  - ADDI 4
  - BEQ 3
  - J 3
  - illegal 2
- Each `mem_ready`=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.
- `op` is sampled in DECODE and MEMADR only. `zero` is sampled in BEQEX only.
- `mem_ready` is ignored in all other states.
- The output-to-state relation is combinational with no added latency. The state register updates on the rising edge.

## Structure
- Shared package `mc_pkg`:
  - 4-bit state encodings: FETCH=0 … JEX=11.
  - Opcode constants.
  - `aluop` constants: ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10.
  - `alusrcb` and `pcsrc` constants.
- Natural sub-module: `mc_outdec`, a combinational state → control-word decoder. The FSM next-state and sticky logic stay in `mc_controller`.

## Test plan
- Reset mid-MEMRD with `mem_ready`=0 → state=0 and all outputs 0 immediately. `reset_n` rises with `mem_ready`=1 → irwrite=pcen=1 on the first edge.
- LW (op=100011) with `mem_ready` tied 1 → state sequence 0,1,2,3,4,0. regwrite=memtoreg=1 in state 4. `instr_done` pulses once.
- SW with `mem_ready` low for 3 cycles in MEMWR → memwrite held 4 cycles, iord=1 throughout. Returns to FETCH after ready.
- BEQ twice:
  - zero=1 → pcen=1, pcsrc=01, aluop=01 in BEQEX.
  - zero=0 → pcen=0. Both take 3 cycles.
- RTYPE then ADDI back-to-back:
  - aluop=10, alusrcb=00 then regdst=1 for RTYPE.
  - aluop=00, alusrcb=10 then regdst=0 for ADDI.
  - 8 cycles total.
- op=111111 → `illegal_op` rises after DECODE and stays 1 across a following J. J yields pcsrc=10, pcen=1 in 3 cycles.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle main controller.
//   - 4-bit state encodings (FETCH=0 .. JEX=11)
//   - supported opcode constants and a legality helper
//   - aluop / alusrcb / pcsrc select encodings
//   - ctrl_t: packed control word driven by the output decoder
package mc_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle.
//   slave  : the controller (consumes op/zero/mem_ready, drives controls)
//   master : the datapath or testbench side
interface mc_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pcen;
  logic       irwrite;
  logic       memwrite;
  logic       iord;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport slave (
    input  op, zero, mem_ready,
    output pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op, state
  );

  modport master (
    output op, zero, mem_ready,
    input  pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op, state
  );
endinterface

// File: rtl/mc_outdec.sv
// Combinational state -> control-word decoder.
//   i_state     : current FSM state
//   i_op        : opcode (only used in DECODE to flag a finished illegal op)
//   i_zero      : ALU zero flag (only used in BEQEX)
//   i_mem_ready : effective memory ready (FETCH/MEMWR strobes)
//   o_ctrl      : full control word including instr_done
module mc_outdec
  import mc_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [5:0] i_op,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    // NOTE: default the whole word first so no branch can infer a latch.
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alusrcb = SRCB_FOUR;
        o_ctrl.irwrite = i_mem_ready;
        o_ctrl.pcen    = i_mem_ready;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut.
        o_ctrl.alusrcb    = SRCB_IMMSH;
        o_ctrl.instr_done = !is_legal_op(i_op);
      end
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.memtoreg   = 1'b1;
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord       = 1'b1;
        o_ctrl.memwrite   = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_RTYPEEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.aluop   = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        o_ctrl.regdst     = 1'b1;
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BEQEX: begin
        o_ctrl.alusrca    = 1'b1;
        o_ctrl.aluop      = ALU_SUB;
        o_ctrl.pcsrc      = PC_ALUOUT;
        o_ctrl.pcen       = i_zero;
        o_ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_JEX: begin
        o_ctrl.pcsrc      = PC_JUMP;
        o_ctrl.pcen       = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle main controller: steps each instruction through fetch, decode,
// execute, memory and writeback and drives all datapath controls.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : op/zero/mem_ready in; control word, instr_done,
//                  sticky illegal_op and debug state out
//   MEM_WAIT     : 1 = stall on mem_ready, 0 = memory always ready
module mc_controller
  import mc_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  mc_if.slave  bus
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_illegal;
  logic       w_rdy;
  ctrl_t      w_dec;
  ctrl_t      w_out;

  assign w_rdy = MEM_WAIT ? bus.mem_ready : 1'b1;

  mc_outdec u_outdec (
    .i_state     (r_state),
    .i_op        (bus.op),
    .i_zero      (bus.zero),
    .i_mem_ready (w_rdy),
    .o_ctrl      (w_dec)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   if (w_rdy) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (w_rdy) w_next = S_MEMWB;
      S_MEMWR:   if (w_rdy) w_next = S_FETCH;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // NOTE: state uses non-blocking assignments and clears asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && !is_legal_op(bus.op))
        r_illegal <= 1'b1;
    end
  end

  // While reset is held every control is forced low, even though FETCH
  // would otherwise present its address-path selects.
  assign w_out = reset_n ? w_dec : '0;

  assign bus.pcen       = w_out.pcen;
  assign bus.irwrite    = w_out.irwrite;
  assign bus.memwrite   = w_out.memwrite;
  assign bus.iord       = w_out.iord;
  assign bus.regwrite   = w_out.regwrite;
  assign bus.regdst     = w_out.regdst;
  assign bus.memtoreg   = w_out.memtoreg;
  assign bus.alusrca    = w_out.alusrca;
  assign bus.alusrcb    = w_out.alusrcb;
  assign bus.pcsrc      = w_out.pcsrc;
  assign bus.aluop      = w_out.aluop;
  assign bus.instr_done = w_out.instr_done;
  assign bus.illegal_op = r_illegal;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the stimulus task derives a per-
// instruction summary from the instruction-level rules and queues it; the
// monitor collects what the controller did and compares on instr_done.
module tb_mc_controller;
  import mc_pkg::*;

  logic clk;
  logic reset_n;
  mc_if bus();

  mc_controller #(.MEM_WAIT(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cycles;
    logic [63:0] trace;
    int          rw;
    int          mw;
    int          io;
    int          pc;
    logic        rdst;
    logic        m2r;
    logic [1:0]  psrc;
    logic [2:0]  fsig;
    logic [3:0]  exsig;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic sticky = 1'b0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic supported(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000,
                     6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [63:0] all_outs();
    return {48'd0, bus.pcen, bus.irwrite, bus.memwrite, bus.iord,
            bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca,
            bus.alusrcb, bus.pcsrc, bus.aluop, bus.instr_done};
  endfunction

  // ---------------- monitor ----------------
  int          m_cyc, m_rw, m_mw, m_io, m_pc;
  logic [63:0] m_tr;
  logic        m_rdst, m_m2r, m_exseen;
  logic [1:0]  m_psrc;
  logic [2:0]  m_fsig;
  logic [3:0]  m_exsig;
  exp_t        m_e;

  task automatic mon_clear();
    m_cyc = 0; m_rw = 0; m_mw = 0; m_io = 0; m_pc = 0; m_tr = '0;
    m_rdst = 0; m_m2r = 0; m_psrc = '0; m_fsig = '0; m_exsig = '0;
    m_exseen = 0;
  endtask

  initial mon_clear();

  always @(negedge clk) begin
    if (!mon_en || !reset_n) mon_clear();
    else begin
      m_cyc++;
      m_tr = {m_tr[59:0], bus.state};
      if (bus.regwrite) begin m_rw++; m_rdst = bus.regdst; m_m2r = bus.memtoreg; end
      if (bus.memwrite) m_mw++;
      if (bus.iord) m_io++;
      if (bus.pcen) begin
        m_pc++;
        if (!bus.irwrite) m_psrc = bus.pcsrc;
      end
      if (bus.irwrite) m_fsig = {bus.iord, bus.alusrcb};
      if (bus.alusrca && !m_exseen) begin
        m_exsig = {bus.alusrcb, bus.aluop};
        m_exseen = 1;
      end
      if (bus.instr_done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_instr_done at %0t", $time);
        end else begin
          m_e = exp_q.pop_front();
          check("cycles",     64'(m_cyc),  64'(m_e.cycles));
          check("state_trace", m_tr,       m_e.trace);
          check("regwrite_n", 64'(m_rw),   64'(m_e.rw));
          check("memwrite_n", 64'(m_mw),   64'(m_e.mw));
          check("iord_n",     64'(m_io),   64'(m_e.io));
          check("pcen_n",     64'(m_pc),   64'(m_e.pc));
          check("regdst",     64'(m_rdst), 64'(m_e.rdst));
          check("memtoreg",   64'(m_m2r),  64'(m_e.m2r));
          check("pcsrc",      64'(m_psrc), 64'(m_e.psrc));
          check("fetch_sel",  64'(m_fsig), 64'(m_e.fsig));
          check("exec_sel",   64'(m_exsig), 64'(m_e.exsig));
          check("illegal_op", 64'(bus.illegal_op), 64'(m_e.ill));
        end
        mon_clear();
      end else if (m_cyc > 20) begin
        checks++; errors++;
        $display("FAIL instr_done_timeout: got %0d cycles without done", m_cyc);
        mon_clear();
      end
    end
  end

  // ---------------- stimulus + reference model ----------------
  // Entered at posedge+1 of the instruction's first (FETCH) cycle.
  task automatic run_instr(input logic [5:0] opc, input int wf, input int wm,
                           input logic z);
    exp_t e;
    logic is_lw, is_sw, is_r, is_beq, is_addi, is_j, ok;
    int   n, mem_i;
    logic [63:0] t;
    is_lw = (opc == OP_LW);    is_sw = (opc == OP_SW);
    is_r  = (opc == OP_RTYPE); is_beq = (opc == OP_BEQ);
    is_addi = (opc == OP_ADDI); is_j = (opc == OP_J);
    ok = supported(opc);
    if (is_lw) n = 5; else if (is_sw || is_r || is_addi) n = 4;
    else if (is_beq || is_j) n = 3; else n = 2;
    if (!(is_lw || is_sw)) wm = 0;
    n = n + wf + wm;

    t = '0;
    for (int i = 0; i <= wf; i++) t = {t[59:0], 4'd0};
    t = {t[59:0], 4'd1};
    if (is_lw) begin
      t = {t[59:0], 4'd2};
      for (int i = 0; i <= wm; i++) t = {t[59:0], 4'd3};
      t = {t[59:0], 4'd4};
    end else if (is_sw) begin
      t = {t[59:0], 4'd2};
      for (int i = 0; i <= wm; i++) t = {t[59:0], 4'd5};
    end else if (is_r)    t = {t[55:0], 4'd6, 4'd7};
    else if (is_beq)      t = {t[59:0], 4'd8};
    else if (is_addi)     t = {t[55:0], 4'd9, 4'd10};
    else if (is_j)        t = {t[59:0], 4'd11};

    e.cycles = n;
    e.trace  = t;
    e.rw     = (is_lw || is_r || is_addi) ? 1 : 0;
    e.mw     = is_sw ? wm + 1 : 0;
    e.io     = (is_lw || is_sw) ? wm + 1 : 0;
    e.pc     = 1 + ((is_beq && z) ? 1 : 0) + (is_j ? 1 : 0);
    e.rdst   = is_r;
    e.m2r    = is_lw;
    e.psrc   = (is_beq && z) ? 2'b01 : is_j ? 2'b10 : 2'b00;
    e.fsig   = 3'b001;
    e.exsig  = (is_lw || is_sw || is_addi) ? 4'b1000 :
               is_r ? 4'b0010 : is_beq ? 4'b0001 : 4'b0000;
    e.ill    = sticky;
    exp_q.push_back(e);
    if (!ok) sticky = 1'b1;

    mem_i = wf + 3;
    for (int i = 0; i < n; i++) begin
      logic mr, zz;
      logic [5:0] o;
      mr = 1'($urandom); zz = 1'($urandom); o = 6'($urandom);
      if (i <= wf) mr = (i == wf);
      else o = opc;
      if ((is_lw || is_sw) && i >= mem_i && i <= mem_i + wm) mr = (i == mem_i + wm);
      if (is_beq && i == wf + 2) zz = z;
      bus.mem_ready = mr; bus.zero = zz; bus.op = o;
      @(posedge clk); #1;
    end
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check("rel_irwrite", 64'(bus.irwrite), 64'd1);
    check("rel_pcen",    64'(bus.pcen),    64'd1);
    check("rel_state",   64'(bus.state),   64'd0);
  endtask

  initial begin
    logic [5:0] rop;
    int k;
    reset_n = 1'b0;
    bus.op = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    #3;
    check("rst_state",   64'(bus.state),      64'd0);
    check("rst_outs",    all_outs(),          64'd0);
    check("rst_illegal", 64'(bus.illegal_op), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    release_reset();
    mon_en = 1'b1;

    // Directed scenarios.
    run_instr(OP_LW,    0, 0, 1'b0);
    run_instr(OP_SW,    0, 3, 1'b0);
    run_instr(OP_BEQ,   0, 0, 1'b1);
    run_instr(OP_BEQ,   0, 0, 1'b0);
    run_instr(OP_RTYPE, 0, 0, 1'b0);
    run_instr(OP_ADDI,  0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(OP_J,     0, 0, 1'b0);
    run_instr(OP_LW,    2, 1, 1'b0);

    // Reset asserted while MEMRD waits on memory.
    mon_en = 1'b0;
    bus.mem_ready = 1'b1; bus.op = OP_LW;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("memrd_wait_state", 64'(bus.state), 64'd3);
    check("memrd_wait_iord",  64'(bus.iord),  64'd1);
    check("sticky_before_rst", 64'(bus.illegal_op), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_state",   64'(bus.state),      64'd0);
    check("midrst_outs",    all_outs(),          64'd0);
    check("midrst_illegal", 64'(bus.illegal_op), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sticky = 1'b0;
    release_reset();
    mon_en = 1'b1;
    run_instr(OP_J, 0, 0, 1'b0);

    // Randomized instruction stream.
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: rop = OP_LW;
        1: rop = OP_SW;
        2: rop = OP_RTYPE;
        3: rop = OP_BEQ;
        4: rop = OP_ADDI;
        5: rop = OP_J;
        default: begin
          rop = 6'($urandom);
          while (supported(rop)) rop = 6'($urandom);
        end
      endcase
      run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    mon_en = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_illegal", 64'(bus.illegal_op), 64'(sticky));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
